ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 105 ++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: an sram-like fetch port with at most one request outstanding,
// and a two-entry output latch that feeds an aligned instruction pair to ID.
module ifu_fetch (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   output logic [31:0] pc,
   output logic        inst_rdata_1_ok,
   output logic        inst_rdata_2_ok,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata_1,
   input  logic [31:0] inst_rdata_2,
   input  logic        id_allowin,
   output logic        id_valid_1,
   output logic        id_valid_2,
   output logic [31:0] id_inst_1,
   output logic [31:0] id_inst_2,
   output logic [31:0] id_pc_1,
   output logic [31:0] id_pc_2
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

   state_t state, state_nxt;
   logic   load;

   assign inst_addr = {pc[31:3], pc[2], 2'b00};

   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc    <= 32'hBFC0_0000;
         state <= S_IDLE;
      end else begin
         pc    <= next_pc;
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt       = state;
      inst_req        = 1'b0;
      inst_rdata_1_ok = 1'b0;
      inst_rdata_2_ok = 1'b0;
      load            = 1'b0;
      case (state)
         S_IDLE: begin
            if (!id_valid_1 || id_allowin) state_nxt = S_REQ;
         end
         S_REQ: begin
            inst_req = 1'b1;
            if (inst_addr_ok) state_nxt = redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            // A redirect kills the in-flight response; if it is not here yet, it must be drained.
            if (redirect) begin
               state_nxt = inst_data_ok ? S_IDLE : S_DROP;
            end else if (inst_data_ok) begin
               load            = 1'b1;
               inst_rdata_1_ok = 1'b1;
               inst_rdata_2_ok = ~pc[2];
               state_nxt       = S_IDLE;
            end
         end
         S_DROP: begin
            if (inst_data_ok) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the latch payload is reset as well as its valid bits, so ID never
   // sees stale words from before reset even while it ignores them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         id_valid_1 <= 1'b0;
         id_valid_2 <= 1'b0;
         id_inst_1  <= '0;
         id_inst_2  <= '0;
         id_pc_1    <= '0;
         id_pc_2    <= '0;
      end else if (redirect) begin
         id_valid_1 <= 1'b0;
         id_valid_2 <= 1'b0;
      end else if (load) begin
         id_valid_1 <= 1'b1;
         id_valid_2 <= ~pc[2];
         id_inst_1  <= inst_rdata_1;
         id_inst_2  <= inst_rdata_2;
         id_pc_1    <= pc;
         id_pc_2    <= pc + 32'd4;
      end else if (id_allowin) begin
         id_valid_1 <= 1'b0;
         id_valid_2 <= 1'b0;
      end
   end

endmodule
